// File: rtl/uart_tx.sv
// UART transmitter: serializes a data word as one start bit, NBITS_DATA data
// bits LSB first, then a stop period. Bit timing is driven by the shared
// baud-rate tick, which arrives OVERSAMPLE times per bit.
module uart_tx #(
  parameter int NBITS_DATA   = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int STOPBITS_TCK = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tick_brg,
  input  logic                  i_tx_start,
  input  logic [NBITS_DATA-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_tx_done,
  output logic                  o_tx_busy
);

  // The tick counter must reach the larger of the bit length and the stop
  // length; both counters keep at least one bit for degenerate parameters.
  localparam int TICK_MAX = (OVERSAMPLE > STOPBITS_TCK) ? OVERSAMPLE : STOPBITS_TCK;
  localparam int TCNT_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BCNT_W   = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;

  localparam logic [TCNT_W-1:0] OS_LAST   = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [TCNT_W-1:0] STOP_LAST = TCNT_W'(STOPBITS_TCK - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(NBITS_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TCNT_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BCNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NBITS_DATA-1:0]   shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;

  // Next-state logic: advance through the frame on baud ticks only.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A tick coinciding with acceptance is deliberately not counted.
        if (i_tx_start) begin
          shift_d    = i_data;
          tick_cnt_d = '0;
          state_d    = START;
        end
      end

      START: begin
        if (i_tick_brg) begin
          if (tick_cnt_q == OS_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (i_tick_brg) begin
          if (tick_cnt_q == OS_LAST) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (i_tick_brg) begin
          if (tick_cnt_q == STOP_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            done_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The line level is derived from the next state so the registered output
    // lines up with the state it belongs to.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A tick-counting frame model predicts the
// serial line, busy and done for every clock; two instances cover the default
// configuration and a 7-bit / 2-stop-bit configuration.
module tb_uart_tx;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       tx_start;
  logic [7:0] data8;

  logic tx8, done8, busy8;
  logic tx7, done7, busy7;

  uart_tx dut8 (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_tick_brg (tick),
    .i_tx_start (tx_start),
    .i_data     (data8),
    .o_tx       (tx8),
    .o_tx_done  (done8),
    .o_tx_busy  (busy8)
  );

  uart_tx #(.NBITS_DATA(7), .OVERSAMPLE(16), .STOPBITS_TCK(32)) dut7 (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_tick_brg (tick),
    .i_tx_start (tx_start),
    .i_data     (data8[6:0]),
    .o_tx       (tx7),
    .o_tx_done  (done7),
    .o_tx_busy  (busy7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  int    clk_cnt = 0;
  int    tick_period = 4;
  bit    tick_pause = 1'b0;
  bit    sel7 = 1'b0;
  string phase = "init";

  // Frame model: a frame is just "ticks elapsed since acceptance".
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_k = 0;
  int         m_n = 8;
  int         m_stop = 16;
  logic [7:0] m_data = 8'h00;

  function automatic logic exp_tx();
    int seg;
    if (!m_busy) return 1'b1;
    seg = m_k / OS;
    if (seg == 0) return 1'b0;
    if (seg <= m_n) return m_data[seg-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%0h expected=%0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  // One clock: drive the tick, advance the model at the edge, check #1 later.
  task automatic cycle();
    logic t;
    t = !tick_pause && (tick_period > 0) && ((clk_cnt % tick_period) == tick_period - 1);
    tick = t;
    @(posedge clk);
    clk_cnt++;
    m_done = 1'b0;
    if (!m_busy) begin
      if (tx_start) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_data = data8;
      end
    end else if (t) begin
      m_k++;
      if (m_k == (1 + m_n) * OS + m_stop) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
    #1;
    check("tx",   sel7 ? tx7   : tx8,   exp_tx());
    check("busy", sel7 ? busy7 : busy8, m_busy);
    check("done", sel7 ? done7 : done8, m_done);
  endtask

  task automatic send(input logic [7:0] d);
    tx_start = 1'b1;
    data8    = d;
    cycle();
    tx_start = 1'b0;
  endtask

  task automatic run_until_k(input int target);
    int n;
    n = 0;
    while (!(m_busy && m_k >= target) && n < 5000) begin
      cycle();
      n++;
    end
    tests++;
    assert (n < 5000) else begin
      fails++;
      $error("FAIL %s/timeout_k observed=%0d expected=%0d", phase, m_k, target);
    end
  endtask

  task automatic run_until_done();
    int n;
    n = 0;
    while (!m_done && n < 8000) begin
      cycle();
      n++;
    end
    tests++;
    assert (n < 8000) else begin
      fails++;
      $error("FAIL %s/timeout_done observed=%0d expected=%0d", phase, n, 8000);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset applied mid-cycle; outputs must react before any edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx8",   tx8,   1'b1);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_tx7",   tx7,   1'b1);
    check("rst_busy7", busy7, 1'b0);
    m_busy = 1'b0;
    m_done = 1'b0;
    m_k    = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    rst_n    = 1'b0;
    tick     = 1'b0;
    tx_start = 1'b0;
    data8    = 8'h00;

    // Reset state
    phase = "reset";
    @(posedge clk);
    @(posedge clk);
    #1;
    check("tx8",   tx8,   1'b1);
    check("busy8", busy8, 1'b0);
    check("done8", done8, 1'b0);
    check("tx7",   tx7,   1'b1);
    check("done7", done7, 1'b0);
    rst_n = 1'b1;
    run_cycles(10);

    // 1: A5 with a tick every 4 clocks
    phase = "frame_a5";
    tick_period = 4;
    send(8'hA5);
    run_until_done();
    run_cycles(20);

    // 2: start request mid-frame is ignored
    phase = "ignore_start";
    send(8'h3C);
    run_until_k(64);
    tx_start = 1'b1;
    data8    = 8'hFF;
    cycle();
    tx_start = 1'b0;
    run_until_done();
    run_cycles(80);

    // 3: reset during bit 4 of 00
    phase = "mid_reset";
    send(8'h00);
    run_until_k(88);
    pulse_reset();
    run_cycles(120);

    // 4: back-to-back frames with start held high
    phase = "back_to_back";
    tx_start = 1'b1;
    data8    = 8'h55;
    cycle();
    run_until_done();
    data8 = 8'hAA;
    cycle();
    tx_start = 1'b0;
    check("b2b_start_bit", tx8, 1'b0);
    run_until_done();
    run_cycles(20);

    // 6: tick stall in the middle of a data bit
    phase = "tick_stall";
    r = 8'($urandom_range(0, 255));
    send(r);
    run_until_k(50);
    tick_pause = 1'b1;
    run_cycles(100);
    tick_pause = 1'b0;
    run_until_done();
    run_cycles(10);

    // Random frames with random tick spacing
    phase = "random8";
    for (int f = 0; f < 3; f++) begin
      tick_period = $urandom_range(1, 5);
      r = 8'($urandom_range(0, 255));
      send(r);
      run_until_done();
      run_cycles($urandom_range(0, 6));
    end

    // 5: 7 data bits, 32-tick stop period
    phase = "cfg7";
    sel7        = 1'b1;
    m_n         = 7;
    m_stop      = 32;
    tick_period = 4;
    pulse_reset();
    run_cycles(5);
    send(8'h41);
    run_until_done();
    run_cycles(10);
    phase = "random7";
    for (int f = 0; f < 2; f++) begin
      tick_period = $urandom_range(1, 4);
      r = 8'($urandom_range(0, 127));
      send(r);
      run_until_done();
      run_cycles(5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
